// File: rtl/key_expand_256_seq_if.sv
// Bus between a key source / round-key reader and the AES-256 key expander.
//
// Handshake: a key transfers on a rising clk edge where key_valid && key_ready
// are both 1. key_valid and key_in are driven by the master and may change
// freely while key_ready is 0 (the expander ignores them then). key_ready is
// 1 whenever the expander is idle or holding a finished schedule.
// rk_rd_idx/rk_rd_data form a combinational read port for the stored
// schedule. fsm_state exposes the expander's FSM for observation.
interface key_expand_256_seq_if;
  logic         key_valid;
  logic [255:0] key_in;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic [1:0]   fsm_state;

  modport master (
    output key_valid, key_in, rk_rd_idx,
    input  key_ready, busy, keys_valid, rk_rd_data, fsm_state
  );

  modport slave (
    input  key_valid, key_in, rk_rd_idx,
    output key_ready, busy, keys_valid, rk_rd_data, fsm_state
  );
endinterface

// File: rtl/key_expand_256_seq.sv
// Sequential AES-256 key expansion: one 8-word schedule step per clock,
// 15 round keys kept in a small register file behind a combinational read port.
module key_expand_256_seq (
  input logic                 clk,
  input logic                 rst,
  key_expand_256_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  state_t         state;
  state_t         state_next;
  logic   [2:0]   cnt;          // schedule step number, 1..7 while expanding
  logic   [255:0] work;         // previous 8 schedule words, w0 in the top bits
  logic   [255:0] step_next;    // 8 new words produced by the current step
  logic   [7:0]   rc;
  logic           accept;
  logic   [127:0] rk_mem [16];  // entry 15 is never written; reads of it return 0

  assign accept        = bus.key_valid && bus.key_ready;
  assign bus.fsm_state = state;

  // State register; reset wins over a simultaneous acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start on acceptance, finish after the seventh step.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXPAND;
      EXPAND:  if (cnt == 3'd7) state_next = DONE;
      DONE:    if (accept) state_next = EXPAND;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded purely from the state.
  always_comb begin
    bus.key_ready  = 1'b0;
    bus.busy       = 1'b0;
    bus.keys_valid = 1'b0;
    case (state)
      IDLE:    bus.key_ready = 1'b1;
      EXPAND:  bus.busy = 1'b1;
      DONE: begin
        bus.key_ready  = 1'b1;
        bus.keys_valid = 1'b1;
      end
      default: bus.key_ready = 1'b0;
    endcase
  end

  // Round constant for the step held in cnt.
  always_comb begin
    rc = 8'h00;
    case (cnt)
      3'd1:    rc = 8'h01;
      3'd2:    rc = 8'h02;
      3'd3:    rc = 8'h04;
      3'd4:    rc = 8'h08;
      3'd5:    rc = 8'h10;
      3'd6:    rc = 8'h20;
      3'd7:    rc = 8'h40;
      default: rc = 8'h00;
    endcase
  end

  // One schedule step: each new word chains off the previous new word, with
  // the RotWord/SubWord/Rcon mix on word 0 and a plain SubWord on word 4.
  always_comb begin
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
    t  = sub_word(rot_word(work[31:0])) ^ {rc, 24'h0};
    n0 = work[255:224] ^ t;
    n1 = n0 ^ work[223:192];
    n2 = n1 ^ work[191:160];
    n3 = n2 ^ work[159:128];
    n4 = sub_word(n3) ^ work[127:96];
    n5 = n4 ^ work[95:64];
    n6 = n5 ^ work[63:32];
    n7 = n6 ^ work[31:0];
    step_next = {n0, n1, n2, n3, n4, n5, n6, n7};
  end

  // Working register and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= 3'd0;
    end else if (accept) begin
      work <= bus.key_in;
      cnt  <= 3'd1;
    end else if (state == EXPAND) begin
      work <= step_next;
      cnt  <= cnt + 3'd1;
    end
  end

  // Round-key storage. Not cleared on reset: the read port hides it until a
  // full schedule is present. The odd half of step 7 is words 60..63, unused.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        rk_mem[0] <= bus.key_in[255:128];
        rk_mem[1] <= bus.key_in[127:0];
      end else if (state == EXPAND) begin
        rk_mem[{cnt, 1'b0}] <= step_next[255:128];
        if (cnt != 3'd7) begin
          rk_mem[{cnt, 1'b1}] <= step_next[127:0];
        end
      end
    end
  end

  // Combinational read port, gated so nothing is visible before DONE.
  always_comb begin
    bus.rk_rd_data = '0;
    if (bus.keys_valid && (bus.rk_rd_idx <= 4'd14)) begin
      bus.rk_rd_data = rk_mem[bus.rk_rd_idx];
    end
  end

endmodule

// File: tb/tb_key_expand_256_seq.sv
// Bench for key_expand_256_seq: FIPS-197 vector, handshake corner cases and
// random keys, compared against a word-by-word AES-256 key schedule model.
module tb_key_expand_256_seq;

  localparam logic [255:0] FIPS_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  logic [127:0] exp_q [$];
  logic [7:0]   sbox_tab [256];
  logic [31:0]  ref_w [60];

  key_expand_256_seq_if bus ();

  key_expand_256_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int k = 1; k < 256; k++) begin
        if (gmul(8'(x), 8'(k)) == 8'h01) inv = 8'(k);
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
               inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      end
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [31:0] ref_sub(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Textbook AES-256 schedule, one word at a time (Nk = 8, 60 words).
  task automatic ref_expand(input logic [255:0] key);
    logic [31:0] temp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) ref_w[i] = key[255 - 32 * i -: 32];
    for (int i = 8; i < 60; i++) begin
      temp = ref_w[i - 1];
      if (i % 8 == 0) begin
        temp = ref_sub({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        temp = ref_sub(temp);
      end
      ref_w[i] = ref_w[i - 8] ^ temp;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic read_rk(input int idx, output logic [127:0] data);
    bus.rk_rd_idx = 4'(idx);
    #1;
    data = bus.rk_rd_data;
  endtask

  // Scoreboard: queue the model's 15 round keys, then sweep every index.
  task automatic verify_keys(input logic [255:0] key, input string tag);
    logic [127:0] got;
    logic [127:0] exp;
    ref_expand(key);
    for (int j = 0; j < 15; j++) begin
      exp_q.push_back({ref_w[4 * j], ref_w[4 * j + 1], ref_w[4 * j + 2], ref_w[4 * j + 3]});
    end
    for (int idx = 0; idx < 16; idx++) begin
      read_rk(idx, got);
      exp = (idx < 15) ? exp_q.pop_front() : 128'h0;
      check_val($sformatf("%s rk%0d", tag, idx), got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Offer a key at posedge+1, then follow the expansion to DONE. When hold is
  // set, key_valid stays high with alt_key on key_in throughout EXPAND.
  task automatic load_key(input logic [255:0] key, input bit hold,
                          input logic [255:0] alt_key, input string tag);
    int edges;
    bus.key_valid = 1'b1;
    bus.key_in    = key;
    @(posedge clk);
    #1;
    check_val({tag, " kv_drop"}, 128'(bus.keys_valid), 128'h0);
    check_val({tag, " busy_start"}, 128'(bus.busy), 128'h1);
    if (hold) bus.key_in = alt_key;
    else bus.key_valid = 1'b0;
    edges = 0;
    while (!bus.keys_valid && edges < 20) begin
      if (bus.key_ready !== 1'b0) begin
        check_val({tag, " ready_low"}, 128'(bus.key_ready), 128'h0);
      end
      @(posedge clk);
      #1;
      edges++;
    end
    bus.key_valid = 1'b0;
    // acceptance edge plus seven EXPAND edges: DONE seven edges after acceptance
    check_val({tag, " latency"}, 128'(edges), 128'd7);
    check_val({tag, " busy_done"}, 128'(bus.busy), 128'h0);
    check_val({tag, " ready_done"}, 128'(bus.key_ready), 128'h1);
  endtask

  task automatic check_idle(input string tag);
    logic [127:0] got;
    check_val({tag, " ready"}, 128'(bus.key_ready), 128'h1);
    check_val({tag, " busy"}, 128'(bus.busy), 128'h0);
    check_val({tag, " kv"}, 128'(bus.keys_valid), 128'h0);
    read_rk(0, got);
    check_val({tag, " rd0"}, got, 128'h0);
  endtask

  task automatic check_fips_literals();
    logic [127:0] got;
    read_rk(0, got);
    check_val("fips rk0", got, 128'h603deb1015ca71be2b73aef0857d7781);
    read_rk(1, got);
    check_val("fips rk1", got, 128'h1f352c073b6108d72d9810a30914dff4);
    read_rk(2, got);
    check_val("fips rk2", got, 128'h9ba354118e6925afa51a8b5f2067fcde);
    read_rk(14, got);
    check_val("fips rk14", got, 128'hfe4890d1e6188d0b046df344706c631e);
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
    return k;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] got;
    n_checks      = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.rk_rd_idx = 4'd0;
    build_sbox();

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");
    for (int idx = 0; idx < 16; idx++) begin
      read_rk(idx, got);
      check_val($sformatf("pre-key rk%0d", idx), got, 128'h0);
    end

    // key_valid and rst on the same edge: reset wins, nothing starts.
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_in    = FIPS_KEY;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.key_valid = 1'b0;
    check_idle("rst+valid");
    @(posedge clk);
    #1;
    check_idle("rst+valid later");

    // FIPS-197 vector.
    load_key(FIPS_KEY, 1'b0, '0, "fips");
    check_fips_literals();
    verify_keys(FIPS_KEY, "fips");

    // key_valid held through EXPAND with a different key: ignored.
    @(posedge clk);
    #1;
    load_key(FIPS_KEY, 1'b1, rand_key(), "hold");
    check_fips_literals();
    verify_keys(FIPS_KEY, "hold");

    // Reset in the 4th EXPAND cycle, then rerun the vector.
    @(posedge clk);
    #1;
    bus.key_valid = 1'b1;
    bus.key_in    = rand_key();
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("abort busy_before", 128'(bus.busy), 128'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("abort");
    load_key(FIPS_KEY, 1'b0, '0, "after abort");
    check_fips_literals();
    verify_keys(FIPS_KEY, "after abort");

    // All-zero key accepted straight from DONE.
    load_key(256'h0, 1'b0, '0, "zero");
    read_rk(1, got);
    check_val("zero rk1", got, 128'h0);
    read_rk(2, got);
    check_val("zero rk2", got, 128'h62636363626363636263636362636363);
    verify_keys(256'h0, "zero");

    // Random keys, some offered while holding key_valid through EXPAND.
    for (int n = 0; n < 6; n++) begin
      logic [255:0] k;
      k = rand_key();
      @(posedge clk);
      #1;
      load_key(k, 1'($urandom_range(0, 1)), rand_key(), $sformatf("rand%0d", n));
      verify_keys(k, $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
